// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: opcode classes, function codes and FSM states.
// No logic of its own; imported by seq_alu and seq_mul_core.
package alu_pkg;

    localparam logic [2:0] OP_RTYPE = 3'b000;
    localparam logic [2:0] OP_ITYPE = 3'b001;

    localparam logic [3:0] FC_XOR   = 4'b0000;
    localparam logic [3:0] FC_AND   = 4'b0001;
    localparam logic [3:0] FC_COMP  = 4'b0010;
    localparam logic [3:0] FC_ADD   = 4'b0011;
    localparam logic [3:0] FC_SHLL  = 4'b0100;
    localparam logic [3:0] FC_SHRL  = 4'b0101;
    localparam logic [3:0] FC_SHLLV = 4'b0110;
    localparam logic [3:0] FC_SHRLV = 4'b0111;
    localparam logic [3:0] FC_SHRA  = 4'b1000;
    localparam logic [3:0] FC_SHRAV = 4'b1001;
    localparam logic [3:0] FC_MULU  = 4'b1010;
    localparam logic [3:0] FC_MULS  = 4'b1011;
    localparam logic [3:0] FC_DIVU  = 4'b1100;

    localparam logic [3:0] FC_ADDI  = 4'b0000;
    localparam logic [3:0] FC_COMPI = 4'b0001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/seq_mul_core.sv
// Iterative shift-add multiplier (signed via magnitudes) with optional restoring divider (SEQ_ALU_DIV_EN).
// Latency: WIDTH steps after start; done is high in the cycle the final step is taken.
// Backpressure: none; the caller holds off start while busy and captures product on done.
module seq_mul_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               signed_mode,
`ifdef SEQ_ALU_DIV_EN
    input  logic               div_mode,
`endif
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH);

    logic               busy;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   opd;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nx;
    logic               neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     sum;
`ifdef SEQ_ALU_DIV_EN
    logic               dmode;
    logic [2*WIDTH:0]   sh;
    logic [WIDTH:0]     diff;
`endif

    // The most-negative value maps to 2^(WIDTH-1), which still fits unsigned.
    assign a_mag = (signed_mode && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign b_mag = (signed_mode && b[WIDTH-1]) ? (~b + 1'b1) : b;

    always_comb begin
        sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opd} : {(WIDTH+1){1'b0}});
        acc_nx = {sum, acc[WIDTH-1:1]};
`ifdef SEQ_ALU_DIV_EN
        // acc holds {remainder, quotient}; a zero divisor naturally yields all-ones / a.
        sh   = {acc, 1'b0};
        diff = sh[2*WIDTH:WIDTH] - {1'b0, opd};
        if (dmode) begin
            if (!diff[WIDTH]) begin
                acc_nx = {diff[WIDTH-1:0], sh[WIDTH-1:1], 1'b1};
            end else begin
                acc_nx = sh[2*WIDTH-1:0];
            end
        end
`endif
    end

    assign done    = busy && (cnt == CW'(WIDTH-1));
    assign product = (neg && (acc_nx != '0)) ? (~acc_nx + 1'b1) : acc_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            cnt   <= '0;
            opd   <= '0;
            acc   <= '0;
            neg   <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
            dmode <= 1'b0;
`endif
        end else if (start) begin
            busy  <= 1'b1;
            cnt   <= '0;
            opd   <= b_mag;
            acc   <= {{WIDTH{1'b0}}, a_mag};
            neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef SEQ_ALU_DIV_EN
            dmode <= div_mode;
`endif
        end else if (busy) begin
            acc <= acc_nx;
            cnt <= cnt + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle logic/add/shift ops, iterative multiply, optional DIVU (SEQ_ALU_DIV_EN).
// Latency: 1 cycle for single-cycle ops, WIDTH+1 cycles for multiply/divide.
// Backpressure: result held in HOLD until out_ready; in_ready only while IDLE.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       opcode,
    input  logic [3:0]       fcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             carry,
    output logic             zero,
    output logic             sign,
    output logic             overflow,
    output logic             illegal
);
    state_t             state, state_nx;
    logic               eng_start, eng_done, ld_alu, ld_eng;
    logic [2*WIDTH-1:0] eng_prod;
    logic [WIDTH:0]     add_s;
    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c, alu_v, is_add, is_comp;
    logic               dec_ill, dec_mul, dec_signed, dec_div;
    logic               muls_q, div_q, dz_q;
    logic [WIDTH-1:0]   res_q, hi_q;
    logic               c_q, z_q, s_q, v_q, ill_q;

    assign add_s = {1'b0, a} + {1'b0, b};
    assign shamt = b[SHW-1:0];

    always_comb begin
        alu_res    = '0;
        is_add     = 1'b0;
        is_comp    = 1'b0;
        dec_ill    = 1'b0;
        dec_mul    = 1'b0;
        dec_signed = 1'b0;
        dec_div    = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (fcode)
                    FC_XOR:             alu_res = a ^ b;
                    FC_AND:             alu_res = a & b;
                    FC_COMP:            is_comp = 1'b1;
                    FC_ADD:             is_add  = 1'b1;
                    FC_SHLL, FC_SHLLV:  alu_res = a << shamt;
                    FC_SHRL, FC_SHRLV:  alu_res = a >> shamt;
                    FC_SHRA, FC_SHRAV:  alu_res = $signed(a) >>> shamt;
                    FC_MULU:            dec_mul = 1'b1;
                    FC_MULS: begin
                        dec_mul    = 1'b1;
                        dec_signed = 1'b1;
                    end
`ifdef SEQ_ALU_DIV_EN
                    FC_DIVU:            dec_div = 1'b1;
`endif
                    default:            dec_ill = 1'b1;
                endcase
            end
            OP_ITYPE: begin
                case (fcode)
                    FC_ADDI:  is_add  = 1'b1;
                    FC_COMPI: is_comp = 1'b1;
                    default:  dec_ill = 1'b1;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
        if (is_add)  alu_res = add_s[WIDTH-1:0];
        if (is_comp) alu_res = ~b + 1'b1;
        alu_c = is_add & add_s[WIDTH];
        alu_v = is_add & (a[WIDTH-1] == b[WIDTH-1]) & (add_s[WIDTH-1] != a[WIDTH-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        eng_start = 1'b0;
        ld_alu    = 1'b0;
        ld_eng    = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (dec_mul || dec_div) begin
                        eng_start = 1'b1;
                        state_nx  = ST_MUL;
                    end else begin
                        ld_alu   = 1'b1;
                        state_nx = ST_HOLD;
                    end
                end
            end
            ST_MUL: begin
                if (eng_done) begin
                    ld_eng   = 1'b1;
                    state_nx = ST_HOLD;
                end
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    seq_mul_core #(.WIDTH(WIDTH)) u_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (eng_start),
        .signed_mode (dec_signed),
`ifdef SEQ_ALU_DIV_EN
        .div_mode    (dec_div),
`endif
        .a           (a),
        .b           (b),
        .done        (eng_done),
        .product     (eng_prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            muls_q <= 1'b0;
            div_q  <= 1'b0;
            dz_q   <= 1'b0;
            res_q  <= '0;
            hi_q   <= '0;
            c_q    <= 1'b0;
            z_q    <= 1'b0;
            s_q    <= 1'b0;
            v_q    <= 1'b0;
            ill_q  <= 1'b0;
        end else begin
            if (eng_start) begin
                muls_q <= dec_signed;
                div_q  <= dec_div;
                dz_q   <= (b == '0);
            end
            if (ld_alu) begin
                res_q <= alu_res;
                hi_q  <= '0;
                c_q   <= alu_c;
                v_q   <= alu_v;
                z_q   <= ~dec_ill & (alu_res == '0);
                s_q   <= alu_res[WIDTH-1];
                ill_q <= dec_ill;
            end
            if (ld_eng) begin
                res_q <= eng_prod[WIDTH-1:0];
                hi_q  <= eng_prod[2*WIDTH-1:WIDTH];
                c_q   <= 1'b0;
                ill_q <= 1'b0;
                // Divide reports quotient-only zero and is unsigned; multiply uses the full product.
                if (div_q) begin
                    v_q <= dz_q;
                    z_q <= (eng_prod[WIDTH-1:0] == '0);
                    s_q <= 1'b0;
                end else begin
                    v_q <= 1'b0;
                    z_q <= (eng_prod == '0);
                    s_q <= muls_q & eng_prod[2*WIDTH-1];
                end
            end
        end
    end

    assign result    = res_q;
    assign result_hi = hi_q;
    assign carry     = c_q;
    assign zero      = z_q;
    assign sign      = s_q;
    assign overflow  = v_q;
    assign illegal   = ill_q;

endmodule

// File: tb/tb_seq_alu.sv
// Randomised bench for seq_alu at WIDTH=32 against an arithmetic reference model, plus pinned literal cases.
module tb_seq_alu;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [2:0]   opcode = '0;
    logic [3:0]   fcode = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready, out_valid, carry, zero, sign, overflow, illegal;
    logic [W-1:0] result, result_hi;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] res;
        logic [31:0] hi;
        logic [4:0]  flg;   // {carry, zero, sign, overflow, illegal}
        int          lat;
    } exp_t;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .fcode(fcode), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .result_hi(result_hi),
        .carry(carry), .zero(zero), .sign(sign), .overflow(overflow), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] opc, input logic [3:0] fc,
                                   input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        logic [32:0] s;
        logic [63:0] p;
        bit          known, is_long, is_signed, is_div;
        logic        c, v;
        e.res = 0; e.hi = 0; e.flg = 0; e.lat = 1;
        c = 0; v = 0; p = 0; s = 0;
        known = 1; is_long = 0; is_signed = 0; is_div = 0;
        if (opc == 3'd0) begin
            case (fc)
                4'd0: e.res = x ^ y;
                4'd1: e.res = x & y;
                4'd2: e.res = 32'd0 - y;
                4'd3: begin s = {1'b0, x} + {1'b0, y}; e.res = s[31:0]; c = s[32];
                            v = (x[31] == y[31]) && (e.res[31] != x[31]); end
                4'd4, 4'd6: e.res = x << y[4:0];
                4'd5, 4'd7: e.res = x >> y[4:0];
                4'd8, 4'd9: e.res = $signed(x) >>> y[4:0];
                4'd10: begin is_long = 1; p = {32'd0, x} * {32'd0, y}; end
                4'd11: begin is_long = 1; is_signed = 1; p = {{32{x[31]}}, x} * {{32{y[31]}}, y}; end
`ifdef SEQ_ALU_DIV_EN
                4'd12: begin
                    is_long = 1; is_div = 1;
                    if (y == 0) begin p = {x, 32'hFFFF_FFFF}; v = 1; end
                    else p = {x % y, x / y};
                end
`endif
                default: known = 0;
            endcase
        end else if (opc == 3'd1) begin
            case (fc)
                4'd0: begin s = {1'b0, x} + {1'b0, y}; e.res = s[31:0]; c = s[32];
                            v = (x[31] == y[31]) && (e.res[31] != x[31]); end
                4'd1: e.res = 32'd0 - y;
                default: known = 0;
            endcase
        end else begin
            known = 0;
        end
        if (!known) begin
            e.res = 0; e.flg = 5'b00001;
        end else if (is_long) begin
            e.res = p[31:0]; e.hi = p[63:32]; e.lat = 33;
            if (is_div) e.flg = {1'b0, e.res == 0, 1'b0, v, 1'b0};
            else        e.flg = {1'b0, p == 0, is_signed & p[63], 1'b0, 1'b0};
        end else begin
            e.flg = {c, e.res == 0, e.res[31], v, 1'b0};
        end
        return e;
    endfunction

    // Cycle-level reference: an accepted op appears lat cycles later and stays until taken.
    exp_t e_now, m_cur, m_pend;
    logic m_busy, m_out;
    int   m_left;

    always_comb e_now = model(opcode, fcode, a, b);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_out  <= 1'b0;
            m_left <= 0;
        end else begin
            if (m_out && out_ready) m_out <= 1'b0;
            if (m_busy) begin
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_out  <= 1'b1;
                    m_cur  <= m_pend;
                end else begin
                    m_left <= m_left - 1;
                end
            end
            if (!m_busy && !m_out && in_valid) begin
                if (e_now.lat == 1) begin
                    m_out <= 1'b1;
                    m_cur <= e_now;
                end else begin
                    m_busy <= 1'b1;
                    m_left <= e_now.lat - 1;
                    m_pend <= e_now;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", in_ready, !m_busy && !m_out);
            chk("out_valid", out_valid, m_out);
            if (m_out && out_valid) begin
                chk("result", result, m_cur.res);
                chk("result_hi", result_hi, m_cur.hi);
                chk("flags", {carry, zero, sign, overflow, illegal}, m_cur.flg);
            end
        end
    end

    int          lat;
    logic [31:0] got_res, got_hi;
    logic [4:0]  got_flg;

    task automatic issue(input logic [2:0] opc, input logic [3:0] fc, input logic [31:0] x,
                         input logic [31:0] y, input int hold, input bit early);
        int t;
        opcode = opc; fcode = fc; a = x; b = y; in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 200) begin
            @(posedge clk); #2;
            out_ready = 1'b0;
            t++;
        end
        chk("accept_ready", in_ready, 1'b1);
        @(posedge clk); #2;
        in_valid = 1'b0; out_ready = 1'b0;
        a = $urandom; b = $urandom; fcode = 4'($urandom); opcode = 3'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #2;
            lat++;
        end
        chk("result_arrives", out_valid, 1'b1);
        got_res = result; got_hi = result_hi;
        got_flg = {carry, zero, sign, overflow, illegal};
        repeat (hold) begin @(posedge clk); #2; end
        out_ready = 1'b1;
        if (!early) begin
            @(posedge clk); #2;
            out_ready = 1'b0;
        end
    endtask

    logic [2:0]  r_op;
    logic [3:0]  r_fc;
    logic [31:0] r_a, r_b;
    int          r_sel;

    initial begin
        #2;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_data", {result_hi, result}, 64'd0);
        chk("rst_flags", {carry, zero, sign, overflow, illegal}, 5'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #2;

        issue(3'd0, 4'd3, 32'h7FFF_FFFF, 32'd1, 0, 0);
        chk("add_ovf_lat", lat, 1);
        chk("add_ovf_res", got_res, 32'h8000_0000);
        chk("add_ovf_flags", got_flg, 5'b00110);

        issue(3'd0, 4'd3, 32'hFFFF_FFFF, 32'd1, 0, 0);
        chk("add_wrap_res", got_res, 32'd0);
        chk("add_wrap_flags", got_flg, 5'b11000);

        issue(3'd0, 4'd8, 32'h8000_0000, 32'd4, 0, 0);
        chk("shra_res", got_res, 32'hF800_0000);
        chk("shra_sign", got_flg[2], 1'b1);

        issue(3'd0, 4'd4, 32'h1234_5678, 32'h0000_0020, 0, 0);
        chk("shll_upper_ignored", got_res, 32'h1234_5678);

        issue(3'd0, 4'd11, 32'hFFFF_FFFB, 32'd3, 0, 0);
        chk("muls_lat", lat, 33);
        chk("muls_prod", {got_hi, got_res}, 64'hFFFF_FFFF_FFFF_FFF1);
        chk("muls_flags", got_flg, 5'b00100);

        issue(3'd0, 4'd11, 32'h8000_0000, 32'h8000_0000, 0, 0);
        chk("muls_minneg", {got_hi, got_res}, 64'h4000_0000_0000_0000);

        issue(3'd0, 4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 0);
        chk("mulu_prod", {got_hi, got_res}, 64'hFFFF_FFFE_0000_0001);
        chk("mulu_flags", got_flg, 5'b00000);

        issue(3'd2, 4'd3, 32'd9, 32'd9, 0, 0);
        chk("illegal_op", {got_res, got_flg}, {32'd0, 5'b00001});

`ifdef SEQ_ALU_DIV_EN
        issue(3'd0, 4'd12, 32'd100, 32'd7, 0, 0);
        chk("divu_q_r", {got_hi, got_res}, {32'd2, 32'd14});
        chk("divu_lat", lat, 33);
        issue(3'd0, 4'd12, 32'd5, 32'd0, 0, 0);
        chk("divu_zero", {got_hi, got_res, got_flg}, {32'd5, 32'hFFFF_FFFF, 5'b00010});
`else
        issue(3'd0, 4'd12, 32'd100, 32'd7, 0, 0);
        chk("fc1100_illegal", got_flg, 5'b00001);
`endif

        // Reset during a multiply: nothing may ever be presented for it.
        opcode = 3'd0; fcode = 4'd11; a = 32'hFFFF_FFFB; b = 32'd3; in_valid = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_data", {result_hi, result}, 64'd0);
        chk("midrst_flags", {out_valid, carry, zero, sign, overflow, illegal}, 6'd0);
        chk("midrst_in_ready", in_ready, 1'b1);
        #5 rst_n = 1'b1;
        @(posedge clk); #2;
        issue(3'd0, 4'd3, 32'd2, 32'd3, 0, 0);
        chk("post_rst_add", {got_hi, got_res}, 64'd5);

        for (int i = 0; i < 200; i++) begin
            r_a = $urandom; r_b = $urandom;
            r_sel = $urandom_range(0, 7);
            if (r_sel == 0) r_a = 32'h8000_0000;
            if (r_sel == 1) r_b = 32'd0;
            if (r_sel == 2) r_b = $urandom_range(0, 40);
            if (r_sel == 3) r_a = 32'hFFFF_FFFF;
            r_sel = $urandom_range(0, 15);
            if (r_sel == 0) begin
                r_op = 3'($urandom_range(2, 7)); r_fc = 4'($urandom);
            end else if (r_sel < 4) begin
                r_op = 3'd1; r_fc = 4'($urandom_range(0, 3));
            end else begin
                r_op = 3'd0; r_fc = 4'($urandom);
            end
            issue(r_op, r_fc, r_a, r_b, $urandom_range(0, 3), $urandom_range(0, 1) == 1);
        end
        @(posedge clk); #2;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
